// File: rtl/fabric_addr_router.sv
// fabric_addr_router: routes one upstream request port to N downstream slaves
// by base/mask decode, keeps responses in order by only ever having a single
// target outstanding, and answers unmapped requests either from a default
// slave or from a built-in error responder.
module fabric_addr_router #(
    parameter int                           N             = 2,
    parameter int                           ADDR_W        = 32,
    parameter int                           DATA_W        = 32,
    parameter int                           MAX_OUTST     = 4,
    parameter bit                           HAS_DEFAULT   = 1'b1,
    parameter int                           DEFAULT_SLAVE = 0,
    parameter logic [N-1:0][ADDR_W-1:0]     SLAVE_BASE    = '0,
    parameter logic [N-1:0][ADDR_W-1:0]     SLAVE_MASK    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_req_valid,
    output logic                  m_req_ready,
    input  logic [ADDR_W-1:0]     m_req_addr,
    input  logic                  m_req_write,
    input  logic [DATA_W-1:0]     m_req_wdata,
    output logic [N-1:0]          s_req_valid,
    input  logic [N-1:0]          s_req_ready,
    output logic [ADDR_W-1:0]     s_req_addr,
    output logic                  s_req_write,
    output logic [DATA_W-1:0]     s_req_wdata,
    input  logic [N-1:0]          s_rsp_valid,
    output logic [N-1:0]          s_rsp_ready,
    input  logic [N*DATA_W-1:0]   s_rsp_rdata,
    input  logic [N-1:0]          s_rsp_err,
    output logic                  m_rsp_valid,
    input  logic                  m_rsp_ready,
    output logic [DATA_W-1:0]     m_rsp_rdata,
    output logic                  m_rsp_err,
    output logic [15:0]           decode_err_cnt
);

    localparam int            TW      = $clog2(N + 1);
    localparam int            CW      = $clog2(MAX_OUTST + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(N);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    logic [TW-1:0] r_cur_tgt;
    logic [CW-1:0] r_outst;
    logic [15:0]   r_err_cnt;

    logic [TW-1:0] w_tgt;
    logic          w_tgt_err;
    logic          w_ok;
    logic          w_accept;
    logic          w_pop;

    // Address decode: lowest-index hit wins, otherwise default slave or error responder.
    always_comb begin
        w_tgt = HAS_DEFAULT ? TW'(DEFAULT_SLAVE) : ERR_TGT;
        for (int i = N - 1; i >= 0; i--) begin
            if ((m_req_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                w_tgt = TW'(i);
            end
        end
    end

    assign w_tgt_err = (w_tgt == ERR_TGT);

    // Only one target may be in flight; a new target waits for a fully drained count.
    assign w_ok = (r_outst == '0) || ((w_tgt == r_cur_tgt) && (r_outst < MAX_CNT));

    // Request issue: steer valid to the decoded slave, ready comes back from it.
    always_comb begin
        s_req_valid = '0;
        m_req_ready = 1'b0;
        if (w_tgt_err) begin
            m_req_ready = w_ok;
        end
        for (int i = 0; i < N; i++) begin
            if (w_tgt == TW'(i)) begin
                s_req_valid[i] = m_req_valid && w_ok;
                m_req_ready    = w_ok && s_req_ready[i];
            end
        end
    end

    assign s_req_addr  = m_req_addr;
    assign s_req_write = m_req_write;
    assign s_req_wdata = m_req_wdata;

    // Response return: only the current target is listened to, and only while something is outstanding.
    always_comb begin
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        s_rsp_ready = '0;
        if (r_outst != '0) begin
            if (r_cur_tgt == ERR_TGT) begin
                m_rsp_valid = 1'b1;
                m_rsp_err   = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (r_cur_tgt == TW'(i)) begin
                    m_rsp_valid    = s_rsp_valid[i];
                    m_rsp_rdata    = s_rsp_rdata[i*DATA_W +: DATA_W];
                    m_rsp_err      = s_rsp_err[i];
                    s_rsp_ready[i] = m_rsp_ready;
                end
            end
        end
    end

    assign w_accept = m_req_valid && m_req_ready;
    assign w_pop    = m_rsp_valid && m_rsp_ready;

    // Target, outstanding count and saturating decode-error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_tgt <= '0;
            r_outst   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_cur_tgt <= w_tgt;
            end
            if (w_accept && !w_pop) begin
                r_outst <= r_outst + CW'(1);
            end else if (!w_accept && w_pop) begin
                r_outst <= r_outst - CW'(1);
            end
            if (w_accept && w_tgt_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign decode_err_cnt = r_err_cnt;

endmodule

// File: doc/fabric_addr_router.md
# fabric_addr_router

Registered-state address router sitting between one upstream fabric master port and N downstream slave ports. It decodes each request address against a per-slave base/mask table and forwards the request with valid/ready handshaking. Per-target outstanding transactions are tracked so responses return in order. Unmapped requests are either sent to a default slave or answered by a built-in error responder, and a saturating decode-error counter is kept.

## Interface
Parameters:
- `N`, 2: number of downstream slaves (1..15).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: write/read data width.
- `MAX_OUTST`, 4: maximum outstanding requests to the current target (1..255).
- `HAS_DEFAULT`, 1: unmapped addresses go to `DEFAULT_SLAVE`; if 0, they go to the internal error responder.
- `DEFAULT_SLAVE`, 0: default slave index (must be < N).
- `SLAVE_BASE[N]`, all 0: per-slave base address.
- `SLAVE_MASK[N]`, all 0: per-slave compare mask.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m_req_valid`  in  1  upstream request valid.
- `m_req_ready`  out  1  upstream request accepted.
- `m_req_addr`  in  ADDR_W  request address.
- `m_req_write`  in  1  1 = write.
- `m_req_wdata`  in  DATA_W  write data.
- `s_req_valid`  out  N  per-slave request valid (one-hot or zero).
- `s_req_ready`  in  N  per-slave request ready.
- `s_req_addr`, `s_req_write`, `s_req_wdata`  out  ADDR_W/1/DATA_W  broadcast copies of the upstream fields.
- `s_rsp_valid`  in  N  per-slave response valid.
- `s_rsp_ready`  out  N  per-slave response ready.
- `s_rsp_rdata`  in  N×DATA_W  per-slave read data.
- `s_rsp_err`  in  N  per-slave error flag.
- `m_rsp_valid`  out  1  upstream response valid.
- `m_rsp_ready`  in  1  upstream response ready.
- `m_rsp_rdata`  out  DATA_W  response data.
- `m_rsp_err`  out  1  response error flag.
- `decode_err_cnt`  out  16  saturating count of requests accepted by the error responder.

## Operation
- **Decode (combinational).**
  - Slave i hits when `(m_req_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]`.
  - The lowest hitting index wins.
  - With no hit, the target is `DEFAULT_SLAVE` if `HAS_DEFAULT`; otherwise the target is ERR (pseudo-index N).
- **State.**
  - `cur_tgt`: width `$clog2(N+1)`.
  - `outst_cnt`: width `$clog2(MAX_OUTST+1)`.
  - `decode_err_cnt`: 16 bits.
- **Issue rule.** Define `ok = (outst_cnt==0) || (tgt==cur_tgt && outst_cnt<MAX_OUTST)`.
  - Real slave: `s_req_valid[tgt] = m_req_valid && ok`; `m_req_ready = ok && s_req_ready[tgt]`.
  - ERR target: `m_req_ready = ok`.
  - No `s_req_valid` bit may assert for a request whose `ok` is 0.
- **Accept** (`m_req_valid && m_req_ready`):
  - `cur_tgt <= tgt`.
  - `outst_cnt` increments.
  - For ERR, `decode_err_cnt` increments, saturating at 0xFFFF.
- **Response path**, active only while `outst_cnt != 0`:
  - Real `cur_tgt`: `m_rsp_valid = s_rsp_valid[cur_tgt]`, rdata and err are muxed from that slave, and `s_rsp_ready[cur_tgt] = m_rsp_ready`.
  - ERR: `m_rsp_valid = 1`, `m_rsp_rdata = 0`, `m_rsp_err = 1`.
  - All other `s_rsp_ready` bits are 0. Responses from non-current slaves are never accepted.
- **Pop** (`m_rsp_valid && m_rsp_ready`): `outst_cnt` decrements.
  - Accept and pop in the same cycle leave `outst_cnt` unchanged.
- **Target switching.** A request to a target other than `cur_tgt` stalls until `outst_cnt` is 0. This includes the cycle in which the last response pops.
  - A switch therefore costs at least one idle cycle after the final response.
- **Write handling.** Writes and reads are tracked identically; every request expects exactly one response.

## Timing
- **Reset values:**
  - `outst_cnt = 0`, `cur_tgt = 0`, `decode_err_cnt = 0`.
  - `m_rsp_valid = 0`, all `s_rsp_ready = 0`, all `s_req_valid = 0`.
  - `m_req_ready` follows the combinational rule (it can be 1 after reset).
- **Request path latency:** zero cycles, combinational from `m_req_*` to `s_req_*` and from `s_req_ready` to `m_req_ready`.
- **Response path latency:** zero cycles from slave responses.
- **ERR response:** earliest valid is the cycle after acceptance. It is held until `m_rsp_ready`, with one response per accepted request.
- **Back-pressure:** with `outst_cnt == MAX_OUTST`, `m_req_ready = 0` even for the same target.
- **Stability:** once `m_rsp_valid` is asserted, the upstream response fields hold until popped.
- **Reset mid-transaction:** all counts clear immediately and asynchronously. In-flight slave responses are dropped because `s_rsp_ready` is 0.

## Test plan
- **Back-to-back same target:** N=2, slave0 base 0x0000_0000 mask 0xF000_0000; issue 4 reads to 0x0000_0010.
  - All 4 are accepted on consecutive cycles and `outst_cnt` reaches 4.
  - A 5th read stalls until the first response pops.
- **Target switch:** with 2 outstanding to slave0, a request to slave1 (base 0x1000_0000) holds `m_req_ready = 0`.
  - It is accepted exactly 1 cycle after the second response pops.
- **Error responder:** `HAS_DEFAULT = 0`, read to 0xF000_0000.
  - Accepted with no `s_req_valid` asserted.
  - The next cycle gives `m_rsp_valid = 1`, `rdata = 0`, `err = 1`.
  - `decode_err_cnt = 1`.
- **Default slave:** `HAS_DEFAULT = 1`, `DEFAULT_SLAVE = 1`, read to 0xF000_0000.
  - `s_req_valid = 2'b10`.
  - `decode_err_cnt` stays 0.
- **Overlap priority and simultaneous events:**
  - Slaves 0 and 1 both match 0x0000_0000; slave0 wins.
  - Accept and pop in the same cycle at `outst_cnt = 2` keep the count at 2.
- **Reset mid-flight:** assert `rst` with 3 outstanding.
  - `outst_cnt = 0`, `m_rsp_valid = 0`.
  - A stale `s_rsp_valid` is ignored; the first post-reset request to any slave is accepted immediately.
